// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and defaults for the ID-stage branch resolution controller.
package branch_resolve_ctrl_pkg;

   localparam int NREG_DEF   = 32;
   localparam int TNEW_W_DEF = 2;
   localparam int RIDX_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decoder/forwarding/CMP side of the branch resolution controller.
interface branch_resolve_ctrl_if
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int TNEW_W = TNEW_W_DEF,
   parameter int RIDX_W = RIDX_W_DEF
);
   logic              wr_valid;
   logic [RIDX_W-1:0] wr_rd;
   logic [TNEW_W-1:0] wr_tnew;
   logic              br_valid;
   logic [RIDX_W-1:0] br_rs;
   logic [RIDX_W-1:0] br_rt;
   logic              br_mode;
   logic              br_ready;
   logic              cmp_go;
   logic [RIDX_W-1:0] cmp_rs;
   logic [RIDX_W-1:0] cmp_rt;
   logic              cmp_mode;
   logic              cmp_res;
   logic              flush;
   logic              stall_id;
   logic              br_done;
   logic              br_taken;

   modport master (
      output wr_valid, wr_rd, wr_tnew, br_valid, br_rs, br_rt, br_mode, cmp_res, flush,
      input  br_ready, cmp_go, cmp_rs, cmp_rt, cmp_mode, stall_id, br_done, br_taken
   );

   modport slave (
      input  wr_valid, wr_rd, wr_tnew, br_valid, br_rs, br_rt, br_mode, cmp_res, flush,
      output br_ready, cmp_go, cmp_rs, cmp_rt, cmp_mode, stall_id, br_done, br_taken
   );
endinterface

// File: rtl/branch_resolve_ctrl_scoreboard.sv
// Per-register countdown of cycles until an in-flight producer result is forwardable.
module branch_resolve_ctrl_scoreboard
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int TNEW_W = TNEW_W_DEF,
   parameter int RIDX_W = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid_i,
   input  logic [RIDX_W-1:0] wr_rd_i,
   input  logic [TNEW_W-1:0] wr_tnew_i,
   input  logic [RIDX_W-1:0] qa_i,
   input  logic [RIDX_W-1:0] qb_i,
   output logic              rdy_a_o,
   output logic              rdy_b_o
);

   logic [TNEW_W-1:0] sb_q [NREG];
   logic [TNEW_W-1:0] sb_d [NREG];

   function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   // A write in the same cycle overrides whatever the counter currently says.
   function automatic logic op_ready(input logic [RIDX_W-1:0] q, input logic [TNEW_W-1:0] cnt,
                                     input logic wv, input logic [RIDX_W-1:0] wrd,
                                     input logic [TNEW_W-1:0] wt);
      if (q == '0)             return 1'b1;
      else if (wv && wrd == q) return (wt == '0);
      else                     return (cnt == '0);
   endfunction

   // The stored count is "remaining cycles as seen from the next cycle", so a
   // write of tnew=N lands as N-1 and the operand is usable N cycles later.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         sb_d[r] = dec_sat(sb_q[r]);
         if (r != 0 && wr_valid_i && wr_rd_i == RIDX_W'(r)) sb_d[r] = dec_sat(wr_tnew_i);
      end
      sb_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) sb_q[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) sb_q[r] <= sb_d[r];
      end
   end

   assign rdy_a_o = op_ready(qa_i, sb_q[qa_i], wr_valid_i, wr_rd_i, wr_tnew_i);
   assign rdy_b_o = op_ready(qb_i, sb_q[qb_i], wr_valid_i, wr_rd_i, wr_tnew_i);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Holds an ID-stage branch until both operands are forwardable, fires one compare, reports outcome.
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int TNEW_W = TNEW_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_resolve_ctrl_if.slave  br_if
);

   localparam int RIDX_W = $clog2(NREG);

   br_state_e         state_q, state_d;
   logic [RIDX_W-1:0] rs_q, rs_d, rt_q, rt_d;
   logic              mode_q, mode_d, taken_q, taken_d;
   logic [RIDX_W-1:0] qa, qb;
   logic              rdy_a, rdy_b;
   logic              br_ready, cmp_go, stall_id, br_done;

   // In IDLE the incoming operands are probed directly so a clean branch skips WAIT.
   assign qa = (state_q == ST_IDLE) ? br_if.br_rs : rs_q;
   assign qb = (state_q == ST_IDLE) ? br_if.br_rt : rt_q;

   branch_resolve_ctrl_scoreboard #(
      .NREG   (NREG),
      .TNEW_W (TNEW_W),
      .RIDX_W (RIDX_W)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid_i (br_if.wr_valid),
      .wr_rd_i    (br_if.wr_rd),
      .wr_tnew_i  (br_if.wr_tnew),
      .qa_i       (qa),
      .qb_i       (qb),
      .rdy_a_o    (rdy_a),
      .rdy_b_o    (rdy_b)
   );

   always_comb begin
      state_d  = state_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      mode_d   = mode_q;
      taken_d  = taken_q;
      br_ready = 1'b0;
      cmp_go   = 1'b0;
      stall_id = 1'b0;
      br_done  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            br_ready = 1'b1;
            stall_id = br_if.br_valid;
            if (br_if.br_valid && !br_if.flush) begin
               rs_d    = br_if.br_rs;
               rt_d    = br_if.br_rt;
               mode_d  = br_if.br_mode;
               state_d = (rdy_a && rdy_b) ? ST_EVAL : ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall_id = 1'b1;
            if (br_if.flush)         state_d = ST_IDLE;
            else if (rdy_a && rdy_b) state_d = ST_EVAL;
         end
         ST_EVAL: begin
            stall_id = 1'b1;
            cmp_go   = 1'b1;
            if (br_if.flush) begin
               state_d = ST_IDLE;
            end else begin
               taken_d = br_if.cmp_res;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            br_done = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rs_q    <= '0;
         rt_q    <= '0;
         mode_q  <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         mode_q  <= mode_d;
         taken_q <= taken_d;
      end
   end

   assign br_if.br_ready = br_ready;
   assign br_if.cmp_go   = cmp_go;
   assign br_if.cmp_rs   = rs_q;
   assign br_if.cmp_rt   = rt_q;
   assign br_if.cmp_mode = mode_q;
   assign br_if.stall_id = stall_id;
   assign br_if.br_done  = br_done;
   assign br_if.br_taken = br_done & taken_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench: stimulus queues expected compare/done events, a monitor checks them.
module tb_branch_resolve_ctrl;

   typedef struct {
      int   cyc;
      int   rs;
      int   rt;
      int   mode;
      int   taken;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t cmp_q[$];
   exp_t done_q[$];

   branch_resolve_ctrl_if bif ();

   branch_resolve_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .br_if (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every compare fire and every done pulse must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bif.cmp_go) begin
            if (cmp_q.size() == 0) chk("unexpected_cmp_go", 1, 0);
            else begin
               e = cmp_q.pop_front();
               chk("cmp_go_cycle", cyc, e.cyc);
               chk("cmp_rs", int'(bif.cmp_rs), e.rs);
               chk("cmp_rt", int'(bif.cmp_rt), e.rt);
               chk("cmp_mode", int'(bif.cmp_mode), e.mode);
            end
         end
         if (bif.br_done) begin
            if (done_q.size() == 0) chk("unexpected_br_done", 1, 0);
            else begin
               e = done_q.pop_front();
               chk("br_done_cycle", cyc, e.cyc);
               chk("br_taken", int'(bif.br_taken), e.taken);
            end
         end
      end
   end

   task automatic push_exp(input int c0, input int rs, input int rt, input int mode, input int res,
                           input int cmp_off, input int done_off);
      exp_t e;
      e.cyc = c0 + cmp_off; e.rs = rs; e.rt = rt; e.mode = mode; e.taken = res;
      cmp_q.push_back(e);
      e.cyc = c0 + done_off;
      done_q.push_back(e);
   endtask

   // Issues a branch (optionally with a same-cycle producer write) and holds it until br_done.
   task automatic run_branch(input string nm, input int rs, input int rt, input int mode, input int res,
                             input int wv, input int wrd, input int wt,
                             input int cmp_off, input int done_off, input int flush_off);
      int c0;
      int stall_cnt;
      bit seen;
      c0 = cyc;
      bif.br_valid = 1'b1; bif.br_rs = 5'(rs); bif.br_rt = 5'(rt); bif.br_mode = 1'(mode);
      bif.cmp_res = 1'(res);
      bif.wr_valid = 1'(wv); bif.wr_rd = 5'(wrd); bif.wr_tnew = 2'(wt);
      bif.flush = (flush_off == 0);
      push_exp(c0, rs, rt, mode, res, cmp_off, done_off);
      stall_cnt = 0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (bif.stall_id) stall_cnt++;
         if (bif.br_done) seen = 1'b1;
         tick();
         bif.wr_valid = 1'b0;
         bif.flush = ((cyc - c0) == flush_off);
      end
      bif.br_valid = 1'b0;
      bif.flush = 1'b0;
      chk({nm, "_done_seen"}, int'(seen), 1);
      chk({nm, "_stall_cycles"}, stall_cnt, done_off);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int c0;
      bif.wr_valid = 0; bif.wr_rd = 0; bif.wr_tnew = 0;
      bif.br_valid = 0; bif.br_rs = 0; bif.br_rt = 0; bif.br_mode = 0;
      bif.cmp_res = 0; bif.flush = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_br_ready", int'(bif.br_ready), 1);
      chk("rst_cmp_go", int'(bif.cmp_go), 0);
      chk("rst_stall_id", int'(bif.stall_id), 0);
      chk("rst_br_done", int'(bif.br_done), 0);
      chk("rst_cmp_rs", int'(bif.cmp_rs), 0);
      rst_n = 1'b1;
      tick();

      // No hazard
      run_branch("nohaz", 8, 9, 1, 1, 0, 0, 0, 1, 2, -1);
      tick();
      // RAW hazard on rs, tnew=2
      run_branch("raw", 8, 9, 0, 0, 1, 8, 2, 3, 4, -1);
      tick();
      // r0 is never pending
      run_branch("r0", 0, 0, 1, 1, 1, 0, 3, 1, 2, -1);
      tick();
      // Hazard on rt with tnew=1: a single WAIT cycle
      run_branch("raw_t1", 3, 7, 1, 1, 1, 7, 1, 2, 3, -1);
      tick();
      // Flush in IDLE blocks acceptance for that cycle
      run_branch("flush_idle", 4, 6, 0, 1, 0, 0, 0, 2, 3, 0);
      tick();
      // Flush in DONE does not suppress the pulse
      run_branch("flush_done", 2, 6, 1, 0, 0, 0, 0, 1, 2, 2);
      tick();

      // Flush in WAIT: branch squashed, no compare, no done
      bif.br_valid = 1; bif.br_rs = 10; bif.br_rt = 11; bif.br_mode = 0; bif.cmp_res = 1;
      bif.wr_valid = 1; bif.wr_rd = 10; bif.wr_tnew = 2;
      tick();
      bif.wr_valid = 0;
      tick();
      bif.flush = 1;
      @(negedge clk);
      chk("flush_wait_stall", int'(bif.stall_id), 1);
      tick();
      bif.flush = 0; bif.br_valid = 0;
      @(negedge clk);
      chk("flush_wait_ready", int'(bif.br_ready), 1);
      chk("flush_wait_nostall", int'(bif.stall_id), 0);
      repeat (4) tick();

      // Override: pending sb[5] rewritten with tnew=0 while waiting on rt=5
      bif.wr_valid = 1; bif.wr_rd = 5; bif.wr_tnew = 3;
      tick();
      bif.wr_valid = 0;
      c0 = cyc;
      bif.br_valid = 1; bif.br_rs = 4; bif.br_rt = 5; bif.br_mode = 0; bif.cmp_res = 0;
      push_exp(c0, 4, 5, 0, 0, 2, 3);
      tick();
      bif.wr_valid = 1; bif.wr_rd = 5; bif.wr_tnew = 0;
      @(negedge clk);
      chk("override_wait_stall", int'(bif.stall_id), 1);
      tick();
      bif.wr_valid = 0;
      repeat (2) tick();
      bif.br_valid = 0;
      repeat (2) tick();

      // Reset in WAIT: immediate return to idle outputs and a cleared scoreboard
      bif.br_valid = 1; bif.br_rs = 12; bif.br_rt = 0; bif.br_mode = 1; bif.cmp_res = 1;
      bif.wr_valid = 1; bif.wr_rd = 12; bif.wr_tnew = 3;
      tick();
      bif.wr_valid = 0;
      #1;
      rst_n = 1'b0; bif.br_valid = 0;
      #1;
      chk("midrst_stall_id", int'(bif.stall_id), 0);
      chk("midrst_br_ready", int'(bif.br_ready), 1);
      chk("midrst_cmp_go", int'(bif.cmp_go), 0);
      #1;
      rst_n = 1'b1;
      tick();
      run_branch("post_rst", 12, 0, 1, 1, 0, 0, 0, 1, 2, -1);
      repeat (3) tick();

      chk("leftover_cmp", cmp_q.size(), 0);
      chk("leftover_done", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
